// File: rtl/cmn_pkg.sv
// Shared helpers for the credit-link blocks (transmitter and receiver-side
// credit issuer). Holds no types; payloads stay type parameters on each block.
package cmn_pkg;

  // Legal credit range; the receiver buffer depth must fall inside it.
  localparam int unsigned CRD_NUM_MIN = 1;
  localparam int unsigned CRD_NUM_MAX = 255;

  // Width of a counter able to hold 0..n inclusive.
  function automatic int unsigned crd_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmn_credit_cnt.sv
// Up/down credit counter with saturation at CREDIT_NUM and a sticky overflow
// flag. Shared by the transmit side and the matching receiver-side issuer.
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset; count resets to CREDIT_NUM
//   inc   - credit returned this cycle
//   dec   - credit consumed this cycle; only asserted while cnt != 0
//   cnt   - current credit count
//   err   - sticky: a return arrived with the counter already full
module cmn_credit_cnt
  import cmn_pkg::*;
#(
  parameter int unsigned CREDIT_NUM = 4,
  parameter int unsigned CNT_W      = crd_w(CREDIT_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W + 1)'(CREDIT_NUM);

  logic [CNT_W:0] sum;
  logic           ovf;

  // One extra bit so full + return is visible before it wraps.
  always_comb begin
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc) - (CNT_W + 1)'(dec);
    ovf = (sum > CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_MAX[CNT_W-1:0];
      err <= 1'b0;
    end else begin
      cnt <= ovf ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
      if (ovf) err <= 1'b1;
    end
  end

endmodule

// File: rtl/cmn_credit_tx.sv
// Transmit end of a credit-based link. Converts a local valid/ready source
// into a registered, non-backpressured beat stream, sending only while a
// credit is held. Credits come back from the receiver as single-cycle pulses.
//
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   s_vld    - upstream payload valid
//   s_rdy    - upstream ready: a credit is held (registered state only)
//   s_pld    - upstream payload
//   tx_vld   - link beat valid, one beat per asserted cycle
//   tx_pld   - link payload, registered
//   crd_rtn  - credit return pulse, one credit per asserted cycle
//   crd_cnt  - credits currently held
//   crd_idle - all credits home and no beat on the link
//   crd_err  - sticky credit-overflow error
module cmn_credit_tx
  import cmn_pkg::*;
#(
  parameter type         PLD_TYPE   = logic,
  parameter int unsigned CREDIT_NUM = 4,
  parameter int unsigned CNT_W      = crd_w(CREDIT_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_vld,
  output logic             s_rdy,
  input  PLD_TYPE          s_pld,
  output logic             tx_vld,
  output PLD_TYPE          tx_pld,
  input  logic             crd_rtn,
  output logic [CNT_W-1:0] crd_cnt,
  output logic             crd_idle,
  output logic             crd_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_NUM);

  logic accept;

  // s_rdy looks only at the held count, so a return never bypasses into
  // the same cycle; it takes effect after the next edge.
  always_comb begin
    s_rdy    = (crd_cnt != '0);
    accept   = s_vld && s_rdy;
    crd_idle = (crd_cnt == CNT_FULL) && !tx_vld;
  end

  cmn_credit_cnt #(
    .CREDIT_NUM (CREDIT_NUM),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (crd_rtn),
    .dec   (accept),
    .cnt   (crd_cnt),
    .err   (crd_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld <= 1'b0;
      tx_pld <= PLD_TYPE'('0);
    end else begin
      tx_vld <= accept;
      if (accept) tx_pld <= s_pld;
    end
  end

endmodule

// File: tb/tb_cmn_credit_tx.sv
module tb_cmn_credit_tx;

  localparam int unsigned CN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic [7:0] s_pld = '0;
  logic       tx_vld;
  logic [7:0] tx_pld;
  logic       crd_rtn = 1'b0;
  logic [2:0] crd_cnt;
  logic       crd_idle;
  logic       crd_err;

  int n_chk  = 0;
  int n_fail = 0;

  cmn_credit_tx #(
    .PLD_TYPE   (logic [7:0]),
    .CREDIT_NUM (CN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_vld    (s_vld),
    .s_rdy    (s_rdy),
    .s_pld    (s_pld),
    .tx_vld   (tx_vld),
    .tx_pld   (tx_pld),
    .crd_rtn  (crd_rtn),
    .crd_cnt  (crd_cnt),
    .crd_idle (crd_idle),
    .crd_err  (crd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credits as a plain integer, link as last-beat state.
  int         m_cred = 0;
  bit         m_vld  = 0;
  logic [7:0] m_pld  = '0;
  bit         m_err  = 0;
  bit         m_live = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cred = CN;
      m_vld  = 0;
      m_pld  = '0;
      m_err  = 0;
      m_live = 1;
    end else begin
      bit take;
      int n;
      take = s_vld && (m_cred > 0);
      n = m_cred + (crd_rtn ? 1 : 0) - (take ? 1 : 0);
      if (n > CN) begin
        n = CN;
        m_err = 1;
      end
      m_cred = n;
      m_vld  = take;
      if (take) m_pld = s_pld;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_s_rdy",    32'(s_rdy),    32'(m_cred > 0));
      chk("m_tx_vld",   32'(tx_vld),   32'(m_vld));
      chk("m_tx_pld",   32'(tx_pld),   32'(m_pld));
      chk("m_crd_cnt",  32'(crd_cnt),  32'(m_cred));
      chk("m_crd_idle", 32'(crd_idle), 32'((m_cred == CN) && !m_vld));
      chk("m_crd_err",  32'(crd_err),  32'(m_err));
    end
  end

  // Beats observed on the link, sampled just after each rising edge.
  logic [7:0] got[$];
  always @(posedge clk) begin
    #1;
    if (rst_n && tx_vld) got.push_back(tx_pld);
  end

  task automatic cyc(input bit v, input logic [7:0] p, input bit r);
    s_vld   = v;
    s_pld   = p;
    crd_rtn = r;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int n0;
    bit rdy;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0);
    chk("rst_cnt",  32'(crd_cnt),  32'd4);
    chk("rst_rdy",  32'(s_rdy),    32'd1);
    chk("rst_vld",  32'(tx_vld),   32'd0);
    chk("rst_idle", 32'(crd_idle), 32'd1);
    chk("rst_err",  32'(crd_err),  32'd0);

    // Burst with no returns: only four beats leave.
    nxt = 1;
    for (int i = 0; i < 6; i++) begin
      rdy = s_rdy;
      cyc(1, 8'(nxt), 0);
      if (rdy) nxt++;
    end
    chk("burst_cnt",   32'(crd_cnt),    32'd0);
    chk("burst_rdy",   32'(s_rdy),      32'd0);
    chk("burst_beats", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("burst_pld", 32'(got[i]), 32'(i + 1));

    // Single return from empty: ready next cycle, then 0x5 goes out.
    cyc(1, 8'h05, 1);
    chk("ret_rdy", 32'(s_rdy), 32'd1);
    cyc(1, 8'h05, 0);
    chk("ret_vld", 32'(tx_vld),  32'd1);
    chk("ret_pld", 32'(tx_pld),  32'h05);
    chk("ret_cnt", 32'(crd_cnt), 32'd0);
    cyc(0, 8'h00, 0);

    // Bring count to 2, then accept and return together.
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("two_cnt", 32'(crd_cnt), 32'd2);
    cyc(1, 8'hA0, 1);
    chk("same_cnt", 32'(crd_cnt), 32'd2);
    n0 = got.size();
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'hB0 + i), 1);
    chk("loop_beats", 32'(got.size() - n0), 32'd20);
    chk("loop_cnt",   32'(crd_cnt),         32'd2);

    // Fill up, then overflow with one extra return.
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("full_cnt", 32'(crd_cnt), 32'd4);
    cyc(0, 8'h00, 1);
    chk("ovf_cnt", 32'(crd_cnt), 32'd4);
    chk("ovf_err", 32'(crd_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'hC0 + i), 0);
      cyc(0, 8'h00, 1);
    end
    chk("sticky_err", 32'(crd_err), 32'd1);
    chk("sticky_cnt", 32'(crd_cnt), 32'd4);

    // Reset asynchronously mid-burst at one credit with a beat on the link.
    cyc(1, 8'h11, 0);
    cyc(1, 8'h12, 0);
    cyc(1, 8'h13, 0);
    chk("pre_cnt", 32'(crd_cnt), 32'd1);
    chk("pre_vld", 32'(tx_vld),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(tx_vld),  32'd0);
    chk("arst_cnt", 32'(crd_cnt), 32'd4);
    chk("arst_err", 32'(crd_err), 32'd0);
    chk("arst_pld", 32'(tx_pld),  32'd0);
    s_vld = 1'b0;
    @(negedge clk);
    cyc(0, 8'h00, 0);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0);
    chk("post_vld0", 32'(tx_vld), 32'd0);
    cyc(1, 8'h77, 0);
    chk("post_vld", 32'(tx_vld), 32'd1);
    chk("post_pld", 32'(tx_pld), 32'h77);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
